// File: rtl/joypad_conditioner.sv
// N-channel button synchroniser/debouncer producing the JOYP register view and its interrupt pulse.
// Optional sticky press latches are compiled in when JOYPAD_LATCH_EN is defined.
module joypad_conditioner #(
    parameter int N_BUTTONS       = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16800,
    parameter int CNT_W           = 15,
    parameter bit ACTIVE_LOW_IN   = 1'b0
) (
    input  logic                 clk4_2,
    input  logic                 reset_n,
    input  logic [N_BUTTONS-1:0] buttons_in,
    input  logic                 p1_wr,
    input  logic [1:0]           p1_wr_data,
`ifdef JOYPAD_LATCH_EN
    input  logic                 latch_clr,
    output logic [N_BUTTONS-1:0] buttons_latched,
`endif
    output logic [7:0]           P1_JOYP,
    output logic [N_BUTTONS-1:0] buttons_stable,
    output logic                 joypad_int_sig
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BUTTONS-1:0] pins;
    logic [N_BUTTONS-1:0] sync_q [SYNC_STAGES];
    logic [N_BUTTONS-1:0] sync;
    logic [CNT_W-1:0]     cnt      [N_BUTTONS];
    logic [CNT_W-1:0]     cnt_next [N_BUTTONS];
    logic [N_BUTTONS-1:0] stable_next;
    logic [1:0]           sel;
    logic [3:0]           nib;
    logic [3:0]           prev_nib;

    // Normalise to 1 = pressed before the pins enter the clock domain.
    assign pins = ACTIVE_LOW_IN ? ~buttons_in : buttons_in;
    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk4_2) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= pins;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    always_comb begin
        stable_next = buttons_stable;
        for (int i = 0; i < N_BUTTONS; i++) begin
            cnt_next[i] = '0;
            if (sync[i] != buttons_stable[i]) begin
                if (cnt[i] == CNT_LAST) stable_next[i] = sync[i];
                else                    cnt_next[i]    = cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk4_2) begin
        if (!reset_n) begin
            for (int i = 0; i < N_BUTTONS; i++) cnt[i] <= '0;
            buttons_stable <= '0;
        end else begin
            for (int i = 0; i < N_BUTTONS; i++) cnt[i] <= cnt_next[i];
            buttons_stable <= stable_next;
        end
    end

    // Select bits are active-low; with both groups selected the lines wire-OR.
    assign nib = ~(({4{~sel[0]}} & buttons_stable[3:0]) |
                   ({4{~sel[1]}} & buttons_stable[7:4]));

    always_ff @(posedge clk4_2) begin
        if (!reset_n) begin
            sel            <= 2'b11;
            P1_JOYP        <= 8'hFF;
            prev_nib       <= 4'hF;
            joypad_int_sig <= 1'b0;
        end else begin
            if (p1_wr) sel <= p1_wr_data;
            P1_JOYP        <= {2'b11, sel, nib};
            prev_nib       <= P1_JOYP[3:0];
            joypad_int_sig <= |(prev_nib & ~P1_JOYP[3:0]);
        end
    end

`ifdef JOYPAD_LATCH_EN
    // A fresh press in the same cycle as a clear must not be lost, so set wins.
    always_ff @(posedge clk4_2) begin
        if (!reset_n) buttons_latched <= '0;
        else buttons_latched <= (buttons_latched & ~{N_BUTTONS{latch_clr}}) |
                                (stable_next & ~buttons_stable);
    end
`endif

endmodule

// File: tb/tb_joypad_conditioner.sv
// Self-checking bench for joypad_conditioner: directed sequences, a vector table and
// randomized traffic compared against a cycle-level behavioural model.
module tb_joypad_conditioner;

    localparam int N  = 8;
    localparam int SS = 2;
    localparam int D  = 4;
    localparam int CW = 3;

    logic         clk4_2 = 1'b0;
    logic         reset_n;
    logic [N-1:0] buttons_in;
    logic         p1_wr;
    logic [1:0]   p1_wr_data;
    logic [7:0]   P1_JOYP;
    logic [N-1:0] buttons_stable;
    logic         joypad_int_sig;
`ifdef JOYPAD_LATCH_EN
    logic         latch_clr;
    logic [N-1:0] buttons_latched;
`endif

    always #5 clk4_2 = ~clk4_2;

    joypad_conditioner #(
        .N_BUTTONS(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D), .CNT_W(CW), .ACTIVE_LOW_IN(1'b0)
    ) dut (
        .clk4_2(clk4_2),
        .reset_n(reset_n),
        .buttons_in(buttons_in),
        .p1_wr(p1_wr),
        .p1_wr_data(p1_wr_data),
`ifdef JOYPAD_LATCH_EN
        .latch_clr(latch_clr),
        .buttons_latched(buttons_latched),
`endif
        .P1_JOYP(P1_JOYP),
        .buttons_stable(buttons_stable),
        .joypad_int_sig(joypad_int_sig)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Behavioural model state
    logic [N-1:0] m_pipe [SS];
    int           m_run  [N];
    logic [N-1:0] m_stable;
    logic [N-1:0] m_latched;
    logic [1:0]   m_sel;
    logic [7:0]   m_p1;
    logic [3:0]   m_prev;
    logic         m_int;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] btn;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_nib(input logic [7:0] st, input logic [1:0] s);
        logic [3:0] r;
        for (int j = 0; j < 4; j++) begin
            r[j] = !((!s[0] && st[j]) || (!s[1] && st[j+4]));
        end
        return r;
    endfunction

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [N-1:0] sync_v;
        logic [N-1:0] nxt;
        if (!reset_n) begin
            for (int k = 0; k < SS; k++) m_pipe[k] = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            m_stable = '0; m_latched = '0; m_sel = 2'b11;
            m_p1 = 8'hFF; m_prev = 4'hF; m_int = 1'b0;
        end else begin
            m_int  = |(m_prev & ~m_p1[3:0]);
            m_prev = m_p1[3:0];
            m_p1   = {2'b11, m_sel, m_nib(m_stable, m_sel)};
            if (p1_wr) m_sel = p1_wr_data;
            sync_v = m_pipe[SS-1];
            nxt    = m_stable;
            for (int i = 0; i < N; i++) begin
                if (sync_v[i] != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        nxt[i]   = sync_v[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
`ifdef JOYPAD_LATCH_EN
            if (latch_clr) m_latched = '0;
            m_latched = m_latched | (nxt & ~m_stable);
`endif
            m_stable = nxt;
            for (int k = SS-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = buttons_in;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk4_2);
        #1;
        if (joypad_int_sig === 1'b1) pulses++;
        chk("model_p1_joyp", P1_JOYP, m_p1);
        chk("model_stable", buttons_stable, m_stable);
        chk("model_int", joypad_int_sig, m_int);
`ifdef JOYPAD_LATCH_EN
        chk("model_latched", buttons_latched, m_latched);
`endif
    endtask

    task automatic write_sel(input logic [1:0] s);
        p1_wr = 1'b1; p1_wr_data = s;
        step();
        p1_wr = 1'b0;
    endtask

    initial begin
        int lat;
        tbl[0] = '{2'b01, 8'h10, 8'hDE};
        tbl[1] = '{2'b10, 8'h10, 8'hEF};
        tbl[2] = '{2'b11, 8'h10, 8'hFF};
        tbl[3] = '{2'b10, 8'h08, 8'hE7};
        tbl[4] = '{2'b00, 8'h11, 8'hCE};
        tbl[5] = '{2'b01, 8'h80, 8'hD7};
        tbl[6] = '{2'b10, 8'h00, 8'hEF};

        reset_n = 1'b0; buttons_in = 8'hFF; p1_wr = 1'b0; p1_wr_data = 2'b00;
`ifdef JOYPAD_LATCH_EN
        latch_clr = 1'b0;
`endif
        @(negedge clk4_2);

        // Reset with every button held
        repeat (3) step();
        chk("reset_p1", P1_JOYP, 8'hFF);
        chk("reset_stable", buttons_stable, 8'h00);
        chk("reset_int", joypad_int_sig, 1'b0);
        reset_n = 1'b1;
        step();
        chk("no_pulse_after_reset", joypad_int_sig, 1'b0);
        buttons_in = 8'h00;
        repeat (10) step();

        // Glitchy A never debounces; steady A lands after SYNC_STAGES+DEBOUNCE_CYCLES
        repeat (3) begin
            buttons_in = 8'h10;
            repeat (3) step();
            buttons_in = 8'h00;
            step();
            chk("glitch_a", buttons_stable[4], 1'b0);
        end
        repeat (4) step();
        chk("glitch_a_final", buttons_stable[4], 1'b0);
        buttons_in = 8'h10;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (buttons_stable[4] && lat == 0) lat = c;
        end
        chk("a_latency", lat, 6);

        // Register view for each select setting
        for (int v = 0; v < 7; v++) begin
            buttons_in = tbl[v].btn;
            write_sel(tbl[v].sel);
            repeat (8) step();
            chk($sformatf("table_%0d", v), P1_JOYP, tbl[v].exp);
        end

        // Down press on the direction group: single pulse; release: none
        buttons_in = 8'h00;
        write_sel(2'b10);
        repeat (10) step();
        pulses = 0;
        buttons_in = 8'h08;
        repeat (10) step();
        chk("down_pulse_count", pulses, 1);
        chk("down_p1", P1_JOYP, 8'hE7);
        pulses = 0;
        buttons_in = 8'h00;
        repeat (10) step();
        chk("release_pulse_count", pulses, 0);
        chk("release_p1", P1_JOYP, 8'hEF);

        // Both groups selected, two lines at once: one pulse
        write_sel(2'b00);
        repeat (10) step();
        pulses = 0;
        buttons_in = 8'h11;
        repeat (10) step();
        chk("both_pulse_count", pulses, 1);
        chk("both_nib", P1_JOYP[3:0], 4'hE);
        buttons_in = 8'h00;
        repeat (10) step();

        // Reset in the middle of B's debounce discards the pending change
        buttons_in = 8'h20;
        repeat (3) step();
        reset_n = 1'b0;
        buttons_in = 8'h00;
        step();
        reset_n = 1'b1;
        repeat (10) step();
        chk("b_aborted", buttons_stable[5], 1'b0);

`ifdef JOYPAD_LATCH_EN
        buttons_in = 8'h80;
        repeat (8) step();
        buttons_in = 8'h00;
        repeat (8) step();
        chk("start_latched", buttons_latched[7], 1'b1);
        latch_clr = 1'b1;
        step();
        latch_clr = 1'b0;
        chk("start_cleared", buttons_latched[7], 1'b0);
        buttons_in = 8'h80;
        repeat (5) step();
        latch_clr = 1'b1;
        step();
        latch_clr = 1'b0;
        chk("set_beats_clr_stable", buttons_stable[7], 1'b1);
        chk("set_beats_clr", buttons_latched[7], 1'b1);
        buttons_in = 8'h00;
        repeat (8) step();
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) buttons_in[$urandom_range(N-1)] ^= 1'b1;
            if ($urandom_range(63) == 0) buttons_in = 8'($urandom);
            p1_wr      = ($urandom_range(15) == 0);
            p1_wr_data = 2'($urandom);
            reset_n    = ($urandom_range(299) != 0);
`ifdef JOYPAD_LATCH_EN
            latch_clr  = ($urandom_range(9) == 0);
`endif
            step();
        end
        reset_n = 1'b1; p1_wr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
